// File: rtl/vga_matrix_output_transmitter.sv
// VGA transmitter: 640x480@60 timing, frame-buffer read requests, gray->RGB.
// Ports: I_CLK/I_RESET(async low)/I_ENABLE/I_FRAME_READY/I_PIXEL in; read addr+strobe, RGB, syncs, DE, frame start out.
module vga_matrix_output_transmitter #(
  parameter int P_PIXEL_DEPTH = 24,
  parameter int P_HACT = 640,
  parameter int P_HFP  = 16,
  parameter int P_HSW  = 96,
  parameter int P_HBP  = 48,
  parameter int P_VACT = 480,
  parameter int P_VFP  = 10,
  parameter int P_VSH  = 2,
  parameter int P_VBP  = 33,
  localparam int P_SUBPIXEL_DEPTH = P_PIXEL_DEPTH / 3,
  localparam int P_FRAME_COLUMN_BITS =
    $clog2(P_HACT + P_HFP + P_HSW + P_HBP),
  localparam int P_FRAME_ROW_BITS =
    $clog2(P_VACT + P_VFP + P_VSH + P_VBP)
) (
  input  logic                           I_CLK,
  input  logic                           I_RESET,
  input  logic                           I_ENABLE,
  input  logic                           I_FRAME_READY,
  input  logic [P_SUBPIXEL_DEPTH-1:0]    I_PIXEL,
  output logic [P_FRAME_COLUMN_BITS-1:0] O_PIXEL_COLUMN,
  output logic [P_FRAME_ROW_BITS-1:0]    O_PIXEL_ROW,
  output logic                           O_READ_ENABLE,
  output logic [P_PIXEL_DEPTH-1:0]       O_PIXEL,
  output logic                           O_HSYNC,
  output logic                           O_VSYNC,
  output logic                           O_DATA_ENABLE,
  output logic                           O_FRAME_START
);

  localparam int CB = P_FRAME_COLUMN_BITS;
  localparam int RB = P_FRAME_ROW_BITS;

  localparam logic [CB-1:0] H_LAST =
    CB'(P_HACT + P_HFP + P_HSW + P_HBP - 1);
  localparam logic [CB-1:0] H_ACT  = CB'(P_HACT);
  localparam logic [CB-1:0] HS_BEG = CB'(P_HACT + P_HFP);
  localparam logic [CB-1:0] HS_END = CB'(P_HACT + P_HFP + P_HSW);

  localparam logic [RB-1:0] V_LAST =
    RB'(P_VACT + P_VFP + P_VSH + P_VBP - 1);
  localparam logic [RB-1:0] V_ACT  = RB'(P_VACT);
  localparam logic [RB-1:0] VS_BEG = RB'(P_VACT + P_VFP);
  localparam logic [RB-1:0] VS_END = RB'(P_VACT + P_VFP + P_VSH);

  typedef enum logic {
    BLANK_FRAME,
    SHOW_FRAME
  } state_t;

  state_t        state_q, state_d;
  logic [CB-1:0] h_q, h_d;
  logic [RB-1:0] v_q, v_d;

  logic at_origin;
  logic active;
  logic show;
  logic read_en;

  logic hs1_q, vs1_q, de1_q, show1_q, fs1_q;
  logic hs2_q, vs2_q, de2_q, fs2_q;
  logic [P_PIXEL_DEPTH-1:0] pix2_q;

  assign at_origin = (h_q == '0) && (v_q == '0);
  assign active    = (h_q < H_ACT) && (v_q < V_ACT);

  always_comb begin
    state_d = state_q;
    if (I_ENABLE && at_origin) begin
      state_d = I_FRAME_READY ? SHOW_FRAME
                              : BLANK_FRAME;
    end
  end

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (I_ENABLE) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // The frame decision taken at (0,0) already covers pixel (0,0),
  // so the request path looks at the next state, not the old one.
  assign show = (state_d == SHOW_FRAME);

  // Gated by reset so no strobe escapes while the block is held.
  assign read_en = I_RESET & I_ENABLE & show & active;

  assign O_READ_ENABLE  = read_en;
  assign O_PIXEL_COLUMN = read_en ? h_q : '0;
  assign O_PIXEL_ROW    = read_en ? v_q : '0;

  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) begin
      state_q <= BLANK_FRAME;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) begin
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      de1_q   <= 1'b0;
      show1_q <= 1'b0;
      fs1_q   <= 1'b0;
    end else if (I_ENABLE) begin
      hs1_q   <= !((h_q >= HS_BEG) && (h_q < HS_END));
      vs1_q   <= !((v_q >= VS_BEG) && (v_q < VS_END));
      de1_q   <= active;
      show1_q <= show;
      fs1_q   <= at_origin;
    end
  end

  // I_PIXEL answers the request made one enabled cycle earlier,
  // which is exactly the position held in stage 1.
  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) begin
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
      de2_q  <= 1'b0;
      fs2_q  <= 1'b0;
      pix2_q <= '0;
    end else if (I_ENABLE) begin
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      de2_q  <= de1_q;
      fs2_q  <= fs1_q;
      pix2_q <= (de1_q && show1_q) ? {3{I_PIXEL}} : '0;
    end
  end

  assign O_HSYNC       = hs2_q;
  assign O_VSYNC       = vs2_q;
  assign O_DATA_ENABLE = de2_q;
  assign O_FRAME_START = fs2_q;
  assign O_PIXEL       = pix2_q;

endmodule
